// File: rtl/vga_scan_timing.sv
// VGA raster generator: pixel clock-enable, scan counters, registered sync/blank
// flags, frame-start pulse and a frame-latched background selector.
module vga_scan_timing #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       bg_type_req,
    output logic       pix_ce,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank_n,
    output logic       vblank,
    output logic       frame_start,
    output logic       bg_type
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] divider;
    logic [DIV_W-1:0] div_next;
    logic [9:0]       x_next;
    logic [9:0]       y_next;
    logic             line_end;
    logic             frame_end;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        div_next  = (divider == DIV_LAST) ? '0 : divider + DIV_W'(1);
        line_end  = (DrawX == H_LAST);
        frame_end = line_end && (DrawY == V_LAST);
        x_next    = DrawX;
        y_next    = DrawY;
        if (pix_ce) begin
            x_next = line_end ? '0 : DrawX + 10'd1;
            if (line_end) begin
                y_next = (DrawY == V_LAST) ? '0 : DrawY + 10'd1;
            end
        end
    end

    // Flags are decoded from the next-state counters so they land on the same
    // edge as DrawX/DrawY and stay coherent with them in every cycle.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            divider     <= '0;
            pix_ce      <= 1'b0;
            DrawX       <= '0;
            DrawY       <= '0;
            hs          <= 1'b1;
            vs          <= 1'b1;
            blank_n     <= 1'b1;
            vblank      <= 1'b0;
            frame_start <= 1'b0;
            bg_type     <= 1'b0;
        end else begin
            divider     <= div_next;
            // Registered from the divider, so the first enable comes CLK_DIV
            // cycles after release; with CLK_DIV = 1 it stays high.
            pix_ce      <= (divider == DIV_LAST);
            DrawX       <= x_next;
            DrawY       <= y_next;
            hs          <= !((x_next >= HS_START) && (x_next <= HS_END));
            vs          <= !((y_next >= VS_START) && (y_next <= VS_END));
            blank_n     <= (x_next < H_VIS) && (y_next < V_VIS);
            vblank      <= (y_next >= V_VIS);
            frame_start <= pix_ce && frame_end;
            if (pix_ce && frame_end) begin
                bg_type <= bg_type_req;
            end
        end
    end

endmodule

// File: tb/tb_vga_scan_timing.sv
// Bench for vga_scan_timing: a full-size instance for line timing and a shrunken
// raster (16 x 12) for frame-level, bg_type and mid-frame reset sequences.
module tb_vga_scan_timing;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       bg_type_req = 1'b0;

    logic       a_pce, a_hs, a_vs, a_blank_n, a_vblank, a_fs, a_bg;
    logic [9:0] a_x, a_y;
    logic       b_pce, b_hs, b_vs, b_blank_n, b_vblank, b_fs, b_bg;
    logic [9:0] b_x, b_y;

    int vectors = 0;
    int miscompares = 0;

    always #5 Clk = ~Clk;

    vga_scan_timing dut_a (
        .Clk(Clk), .Reset(Reset), .bg_type_req(bg_type_req),
        .pix_ce(a_pce), .DrawX(a_x), .DrawY(a_y), .hs(a_hs), .vs(a_vs),
        .blank_n(a_blank_n), .vblank(a_vblank), .frame_start(a_fs), .bg_type(a_bg)
    );

    // Small raster: H_TOTAL = 16 (hs low at x 10..12), V_TOTAL = 12 (vs low at y 8..9).
    vga_scan_timing #(
        .CLK_DIV(2), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) dut_b (
        .Clk(Clk), .Reset(Reset), .bg_type_req(bg_type_req),
        .pix_ce(b_pce), .DrawX(b_x), .DrawY(b_y), .hs(b_hs), .vs(b_vs),
        .blank_n(b_blank_n), .vblank(b_vblank), .frame_start(b_fs), .bg_type(b_bg)
    );

    typedef struct {
        int   cyc;
        logic pce;
        int   x;
        int   y;
        logic hs;
        logic blank_n;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge Clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int hs_low;
        int n;
        int k;
        int fs_early, vs_low, vb_hi, hs_lo_b, coh_err, bad;

        // cyc = rising edges since reset release; p = (cyc-1)/2 pixels advanced.
        vecs[0]  = '{1,    1'b0, 0,   0, 1'b1, 1'b1};
        vecs[1]  = '{2,    1'b1, 0,   0, 1'b1, 1'b1};
        vecs[2]  = '{3,    1'b0, 1,   0, 1'b1, 1'b1};
        vecs[3]  = '{1280, 1'b1, 639, 0, 1'b1, 1'b1};
        vecs[4]  = '{1281, 1'b0, 640, 0, 1'b1, 1'b0};
        vecs[5]  = '{1312, 1'b1, 655, 0, 1'b1, 1'b0};
        vecs[6]  = '{1313, 1'b0, 656, 0, 1'b0, 1'b0};
        vecs[7]  = '{1504, 1'b1, 751, 0, 1'b0, 1'b0};
        vecs[8]  = '{1505, 1'b0, 752, 0, 1'b1, 1'b0};
        vecs[9]  = '{1600, 1'b1, 799, 0, 1'b1, 1'b0};
        vecs[10] = '{1601, 1'b0, 0,   1, 1'b1, 1'b1};

        // Reset state while held low.
        repeat (3) step();
        check("rst a DrawX", a_x, 0);
        check("rst a DrawY", a_y, 0);
        check("rst a hs", a_hs, 1);
        check("rst a vs", a_vs, 1);
        check("rst a blank_n", a_blank_n, 1);
        check("rst a vblank", a_vblank, 0);
        check("rst a pix_ce", a_pce, 0);
        check("rst a frame_start", a_fs, 0);
        check("rst a bg_type", a_bg, 0);
        check("rst b DrawY", b_y, 0);

        Reset = 1'b1;
        cyc = 0;
        hs_low = 0;
        for (int i = 0; i < 11; i++) begin
            while (cyc < vecs[i].cyc) begin
                step();
                cyc++;
                if (!a_hs) hs_low++;
            end
            check($sformatf("vec%0d pix_ce", i), a_pce, vecs[i].pce);
            check($sformatf("vec%0d DrawX", i), a_x, vecs[i].x);
            check($sformatf("vec%0d DrawY", i), a_y, vecs[i].y);
            check($sformatf("vec%0d hs", i), a_hs, vecs[i].hs);
            check($sformatf("vec%0d blank_n", i), a_blank_n, vecs[i].blank_n);
            check($sformatf("vec%0d vs", i), a_vs, 1);
        end
        check("line hs low clks", hs_low, 192);

        // Full frame on the small raster: 16*12*2 = 384 clocks per frame.
        n = 0;
        do begin step(); n++; end while (!b_fs && n < 2000);
        check("frame_start found", b_fs, 1);
        check("frame_start DrawX", b_x, 0);
        check("frame_start DrawY", b_y, 0);
        fs_early = 0; vs_low = 0; vb_hi = 0; hs_lo_b = 0; coh_err = 0;
        for (int i = 1; i <= 384; i++) begin
            step();
            if (i < 384 && b_fs) fs_early++;
            if (!b_vs) vs_low++;
            if (!b_hs) hs_lo_b++;
            if (b_vblank) vb_hi++;
            if ((!b_vs) != (b_y >= 8 && b_y <= 9)) coh_err++;
            if ((!b_hs) != (b_x >= 10 && b_x <= 12)) coh_err++;
            if (b_vblank != (b_y >= 6)) coh_err++;
            if (b_blank_n != (b_x < 8 && b_y < 6)) coh_err++;
        end
        check("frame_start width/spacing", fs_early, 0);
        check("frame_start period 384", b_fs, 1);
        check("frame vs low clks", vs_low, 64);
        check("frame hs low clks", hs_lo_b, 72);
        check("frame vblank clks", vb_hi, 192);
        check("frame flag coherence", coh_err, 0);

        // Mid-frame request change is held off until the next frame wrap.
        n = 0;
        do begin step(); n++; end while (b_y != 3 && n < 1000);
        check("reach DrawY 3", b_y, 3);
        bg_type_req = 1'b1;
        bad = 0; n = 0;
        do begin
            step(); n++;
            if (!b_fs && b_bg != 1'b0) bad++;
        end while (!b_fs && n < 1000);
        check("bg_type held mid-frame", bad, 0);
        check("bg wrap frame_start", b_fs, 1);
        check("bg_type after wrap", b_bg, 1);

        // Request toggles in the exact wrap cycle: value at that edge wins.
        bad = 0; n = 0;
        do begin
            step(); n++;
            if (b_bg != 1'b1) bad++;
        end while (!(b_x == 15 && b_y == 11 && b_pce) && n < 1000);
        check("bg_type stable whole frame", bad, 0);
        check("wrap cycle found", b_pce, 1);
        bg_type_req = 1'b0;
        step();
        check("toggle wrap frame_start", b_fs, 1);
        check("bg_type toggled at wrap", b_bg, 0);

        // Mid-frame reset and restart.
        bg_type_req = 1'b1;
        n = 0;
        do begin step(); n++; end while (!(b_x == 5 && b_y == 4) && n < 1000);
        check("reach (5,4)", b_x + 16 * b_y, 69);
        Reset = 1'b0;
        #1;
        check("mid rst DrawX", b_x, 0);
        check("mid rst DrawY", b_y, 0);
        check("mid rst hs", b_hs, 1);
        check("mid rst vs", b_vs, 1);
        check("mid rst blank_n", b_blank_n, 1);
        check("mid rst vblank", b_vblank, 0);
        check("mid rst pix_ce", b_pce, 0);
        check("mid rst frame_start", b_fs, 0);
        check("mid rst a DrawX", a_x, 0);
        repeat (3) step();
        Reset = 1'b1;
        step();
        check("restart k1 pix_ce", b_pce, 0);
        check("restart k1 frame_start", b_fs, 0);
        step();
        check("restart k2 pix_ce", b_pce, 1);
        check("restart k2 DrawX", b_x, 0);
        step();
        check("restart k3 DrawX", b_x, 1);
        k = 3;
        do begin step(); k++; end while (!b_fs && k < 1000);
        check("first frame_start cycle", k, 385);
        check("first frame_start DrawX", b_x, 0);
        check("first frame_start DrawY", b_y, 0);
        check("bg_type loaded on first wrap", b_bg, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_scan_timing.md
Name: vga_scan_timing

Overview:
- Generates the VGA raster for the video pipeline: pixel-rate enable, horizontal and vertical scan counters, sync pulses and blanking.
- Feeds DrawX/DrawY and a frame-stable bg_type directly to the background renderer and sprite stages.
- Frame-boundary pulses drive game-logic updates.
- Runs entirely on the 50 MHz system clock; the pixel rate is produced by a clock-enable, not a derived clock.

Parameters:
- CLK_DIV, 2, system clocks per pixel (>=1)
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset  in  1  asynchronous, active-low reset
- bg_type_req  in  1  requested background type from game logic
- pix_ce  out  1  one-Clk pixel enable, asserted once every CLK_DIV cycles
- DrawX  out  10  current horizontal count, 0..H_TOTAL-1
- DrawY  out  10  current vertical count, 0..V_TOTAL-1
- hs  out  1  horizontal sync, active-low
- vs  out  1  vertical sync, active-low
- blank_n  out  1  high while DrawX < H_VISIBLE and DrawY < V_VISIBLE
- vblank  out  1  high while DrawY >= V_VISIBLE
- frame_start  out  1  one-Clk pulse marking entry to (0,0)
- bg_type  out  1  frame-latched background type for the renderer

Behaviour:
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525).
- Reset asserted: all flops clear immediately. Reset values:
  - divider = 0, pix_ce = 0
  - DrawX = 0, DrawY = 0
  - hs = 1, vs = 1, blank_n = 1, vblank = 0
  - frame_start = 0, bg_type = 0
- Divider counts 0..CLK_DIV-1 and wraps. pix_ce = 1 in the cycle where divider == CLK_DIV-1. For CLK_DIV = 1, pix_ce is held high after reset release.
- Counter advance happens only on a Clk edge where pix_ce = 1:
  - DrawX increments; at H_TOTAL-1 it wraps to 0 and DrawY increments.
  - DrawY at V_TOTAL-1 with DrawX at H_TOTAL-1 wraps to 0.
  - DrawX/DrawY never exceed H_TOTAL-1 / V_TOTAL-1.
- hs, vs, blank_n, vblank are registered from the next-state counter values, so they change on the same edge as DrawX/DrawY and always match them. No combinational decode on the outputs.
  - hs = 0 iff H_VISIBLE+H_FP <= DrawX <= H_VISIBLE+H_FP+H_SYNC-1 (656..751).
  - vs = 0 iff V_VISIBLE+V_FP <= DrawY <= V_VISIBLE+V_FP+V_SYNC-1 (490..491).
  - vs is line-aligned: it changes only when DrawX wraps to 0.
- frame_start: high for exactly one Clk cycle, the first cycle in which DrawX = 0 and DrawY = 0 after a wrap. It is not asserted out of reset.
- bg_type: loads bg_type_req on the same edge the counters wrap to (0,0); otherwise held.
  - A bg_type_req change mid-frame never alters bg_type until the next frame.
  - bg_type_req sampled on the wrap edge wins, including when it toggles in that same cycle.
- Reset mid-frame: counters return to (0,0) asynchronously. On release, scanning restarts with the divider at 0, so the first pix_ce is CLK_DIV cycles after release. No frame_start is issued for the truncated frame.
- Latency: no pipeline. DrawX/DrawY/sync/blank are mutually coherent in every cycle. Downstream stages add their own delay.

Test Plan:
- Hold Reset low, then release:
  - during reset: DrawX = DrawY = 0, hs = vs = blank_n = 1, frame_start = 0, bg_type = 0.
  - first pix_ce at Clk cycle 2 after release; DrawX = 1 one cycle later.
- Run one line (CLK_DIV = 2):
  - DrawX steps 0..799 every 2 Clks and returns to 0 after 1600 Clks, with DrawY = 1.
  - hs low for exactly DrawX 656..751 (192 Clks).
  - blank_n low from DrawX 640.
- Run a full frame:
  - vs low for DrawY 490..491 only (1600 Clks each).
  - vblank high for DrawY 480..524.
  - frame_start pulses once per 840000 Clks, each pulse exactly 1 Clk wide, coincident with DrawX = DrawY = 0.
- Toggle bg_type_req 0 to 1 at DrawY = 200: bg_type stays 0 until the frame wrap, then becomes 1 for the whole next frame.
- Toggle bg_type_req in the exact wrap cycle: bg_type takes the value present at that edge.
- Assert Reset at DrawX = 300, DrawY = 250 for 3 Clks:
  - outputs return to reset values immediately.
  - after release, scanning restarts from (0,0) with no frame_start until the first full wrap.
